mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the CPU datapath (PC, instruction register, register file, ALU, memory/IO port) over several clocks per instruction.
- Replaces the single-cycle combinational decoder when the datapath is rebuilt multi-cycle.
- Generates every mux select and write enable, and stalls on the memory/IO ready handshake.

Parameters:
- STATE_W, 4, width of state register and state_out debug port

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  inst[31:26] from the instruction register
- funct  in  6  inst[5:0] from the instruction register
- zero  in  1  ALU zero flag, valid in the EX_BR cycle
- MIO_ready  in  1  memory/IO ready; an access completes in the cycle it is 1
- PCWrite  out  1  PC load enable (unconditional OR taken branch)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_r  out  1  memory read request
- mem_w  out  1  memory write request
- CPU_MIO  out  1  memory/IO access active (mem_r | mem_w)
- IRWrite  out  1  instruction register load
- RegDst  out  2  write-address select: 0 = rt, 1 = rd, 2 = 31
- MemtoReg  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = rs data
- ALUSrcB  out  2  0 = rt data, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- ALU_Control  out  3  ALU op code (package encoding)
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- state_out  out  STATE_W  current state, debug only

Behaviour:
- Reset: while rst = 1, all outputs are driven 0 and state <= IF; the first IF cycle follows the first clock with rst = 0. Reset mid-instruction aborts it with no register or memory write.
- State register is the only flop. Outputs decode combinationally from state, opcode, funct and zero.
- States and transitions:
  - IF: mem_r = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ALU add, PCSource = 0. When MIO_ready = 1: IRWrite = 1, PCWrite = 1, go to ID. Otherwise hold IF with IRWrite and PCWrite 0.
  - ID: ALUSrcA = 0, ALUSrcB = 3, ALU add (branch target into ALUOut). Dispatch on opcode:
    - 000000 -> EX_R
    - lw 100011 / sw 101011 -> MEM_ADR
    - beq 000100 / bne 000101 -> EX_BR
    - j 000010 -> EX_J
    - jal 000011 -> EX_JAL
    - addi 001000 / andi 001100 / ori 001101 / slti 001010 -> EX_I
    - anything else -> illegal handling
  - EX_R: ALUSrcA = 1, ALUSrcB = 0, ALU_Control from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 100110 xor, 000010 srl. Unknown funct -> illegal handling. Next WB_R.
  - WB_R: RegDst = 1, MemtoReg = 0, RegWrite = 1 -> IF.
  - MEM_ADR: ALUSrcA = 1, ALUSrcB = 2, add -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: IorD = 1, mem_r = 1; hold until MIO_ready, then WB_LW.
  - WB_LW: RegDst = 0, MemtoReg = 1, RegWrite = 1 -> IF.
  - MEM_WR: IorD = 1, mem_w = 1; hold until MIO_ready, then IF. mem_w is asserted every held cycle.
  - EX_BR: ALUSrcA = 1, ALUSrcB = 0, sub, PCSource = 1. PCWrite = zero for beq, ~zero for bne -> IF.
  - EX_J: PCSource = 2, PCWrite = 1 -> IF.
  - EX_JAL: PCSource = 2, PCWrite = 1, RegDst = 2, MemtoReg = 2, RegWrite = 1 (old PC+4) -> IF.
  - EX_I: ALUSrcA = 1, ALUSrcB = 2; op add/and/or/slt per opcode. andi/ori use the sign-ext path; zero-ext is out of scope. Next WB_I.
  - WB_I: RegDst = 0, MemtoReg = 0, RegWrite = 1 -> IF.
- Latency with MIO_ready tied 1: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j/jal 3. Each MIO_ready = 0 cycle in IF, MEM_RD or MEM_WR adds one cycle.
- Any output not listed for a state is 0. CPU_MIO = mem_r | mem_w.
- Unused state encodings go to IF with all outputs 0.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal opcode/funct enters TRAP. All enables are 0, state_out = 4'hF, and TRAP holds until rst.
- Undefined: an illegal opcode/funct is treated as NOP and returns to IF the next cycle with no writes.

Decomposition:
- Package mc_ctrl_pkg holds: state encodings (IF = 0 … TRAP = 15), opcode and funct constants, the ALU_Control encoding (000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 xor, 101 srl), and the RegDst, MemtoReg, ALUSrcB and PCSource select constants.
- One sub-module, mc_alu_dec, maps (state, opcode, funct) to ALU_Control plus an illegal flag; it is purely combinational.

Test Plan:
- rst = 1 for 3 cycles, then 0 -> all outputs 0 during reset; state_out = 0 and mem_r = 1 in the first cycle after release.
- MIO_ready = 1, opcode 000000 funct 100010 -> states IF, ID, EX_R, WB_R; ALU_Control = 110 in EX_R; RegWrite = 1, RegDst = 1 only in WB_R.
- lw with MIO_ready low for 2 cycles in MEM_RD -> 7 cycles total; mem_r and IorD = 1 held for 3 cycles; RegWrite pulse = 1 cycle.
- beq with zero = 1 -> PCWrite = 1, PCSource = 1 in EX_BR. bne with zero = 1 -> PCWrite = 0 in EX_BR.
- jal -> EX_JAL drives RegDst = 2, MemtoReg = 2, RegWrite = 1, PCWrite = 1, PCSource = 2.
- opcode 111111, run once with the macro defined and once without -> state_out = F held with no writes (defined); IF on the cycle after ID with no writes (undefined).

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcodes, functs,
// ALU op codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_EX_R    = 4'd2,
      S_WB_R    = 4'd3,
      S_MEM_ADR = 4'd4,
      S_MEM_RD  = 4'd5,
      S_WB_LW   = 4'd6,
      S_MEM_WR  = 4'd7,
      S_EX_BR   = 4'd8,
      S_EX_J    = 4'd9,
      S_EX_JAL  = 4'd10,
      S_EX_I    = 4'd11,
      S_WB_I    = 4'd12,
      S_TRAP    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_XOR = 6'b100110;
   localparam logic [5:0] F_SRL = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU op decode for the multi-cycle controller, with a flag
// raised for any unsupported opcode or R-type funct encoding.
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       illegal
);

   logic [2:0] r_alu;
   logic       r_ok;
   logic [2:0] i_alu;
   logic       op_ok;

   always_comb begin
      r_alu = ALU_AND;
      r_ok  = 1'b1;
      case (funct)
         F_ADD:   r_alu = ALU_ADD;
         F_SUB:   r_alu = ALU_SUB;
         F_AND:   r_alu = ALU_AND;
         F_OR:    r_alu = ALU_OR;
         F_NOR:   r_alu = ALU_NOR;
         F_SLT:   r_alu = ALU_SLT;
         F_XOR:   r_alu = ALU_XOR;
         F_SRL:   r_alu = ALU_SRL;
         default: r_ok  = 1'b0;
      endcase
   end

   always_comb begin
      i_alu = ALU_AND;
      op_ok = 1'b1;
      case (opcode)
         OP_ADDI: i_alu = ALU_ADD;
         OP_ANDI: i_alu = ALU_AND;
         OP_ORI:  i_alu = ALU_OR;
         OP_SLTI: i_alu = ALU_SLT;
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: op_ok = 1'b1;
         default: op_ok = 1'b0;
      endcase
   end

   // Illegal is instruction-wide so the ID dispatch can catch bad functs too.
   assign illegal = !op_ok || ((opcode == OP_RTYPE) && !r_ok);

   always_comb begin
      alu_ctrl = ALU_AND;
      case (state)
         S_IF, S_ID, S_MEM_ADR: alu_ctrl = ALU_ADD;
         S_EX_R:                alu_ctrl = r_alu;
         S_EX_BR:               alu_ctrl = ALU_SUB;
         S_EX_I:                alu_ctrl = i_alu;
         default:               alu_ctrl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM. Define MC_CTRL_ILLEGAL_TRAP_EN to park illegal
// instructions in TRAP until reset; otherwise they retire as NOPs.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               MIO_ready,
   output logic               PCWrite,
   output logic               IorD,
   output logic               mem_r,
   output logic               mem_w,
   output logic               CPU_MIO,
   output logic               IRWrite,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALU_Control,
   output logic [1:0]         PCSource,
   output logic [STATE_W-1:0] state_out
);

   state_t     state;
   logic [2:0] alu_ctrl;
   logic       illegal;

   mc_alu_dec u_alu_dec (
      .state    (state),
      .opcode   (opcode),
      .funct    (funct),
      .alu_ctrl (alu_ctrl),
      .illegal  (illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IF;
      end else begin
         case (state)
            S_IF:      if (MIO_ready) state <= S_ID;
            S_ID: begin
               if (illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state <= S_TRAP;
`else
                  state <= S_IF;
`endif
               end else begin
                  case (opcode)
                     OP_RTYPE:                         state <= S_EX_R;
                     OP_LW, OP_SW:                     state <= S_MEM_ADR;
                     OP_BEQ, OP_BNE:                   state <= S_EX_BR;
                     OP_J:                             state <= S_EX_J;
                     OP_JAL:                           state <= S_EX_JAL;
                     OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= S_EX_I;
                     default:                          state <= S_IF;
                  endcase
               end
            end
            S_EX_R:    state <= S_WB_R;
            S_WB_R:    state <= S_IF;
            S_MEM_ADR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (MIO_ready) state <= S_WB_LW;
            S_WB_LW:   state <= S_IF;
            S_MEM_WR:  if (MIO_ready) state <= S_IF;
            S_EX_BR:   state <= S_IF;
            S_EX_J:    state <= S_IF;
            S_EX_JAL:  state <= S_IF;
            S_EX_I:    state <= S_WB_I;
            S_WB_I:    state <= S_IF;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:    state <= S_TRAP;
`else
            S_TRAP:    state <= S_IF;
`endif
            default:   state <= S_IF;
         endcase
      end
   end

   // Reset forces every output low, even in the cycle state is still unknown.
   always_comb begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      mem_r    = 1'b0;
      mem_w    = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = RD_RT;
      MemtoReg = M2R_ALUOUT;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_RT;
      PCSource = PCS_ALU;
      if (!rst) begin
         case (state)
            S_IF: begin
               mem_r    = 1'b1;
               ALUSrcB  = SRCB_FOUR;
               IRWrite  = MIO_ready;
               PCWrite  = MIO_ready;
            end
            S_ID:      ALUSrcB = SRCB_IMM_SH;
            S_EX_R:    ALUSrcA = 1'b1;
            S_WB_R: begin
               RegDst   = RD_RD;
               RegWrite = 1'b1;
            end
            S_MEM_ADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
               IorD  = 1'b1;
               mem_r = 1'b1;
            end
            S_WB_LW: begin
               MemtoReg = M2R_MDR;
               RegWrite = 1'b1;
            end
            S_MEM_WR: begin
               IorD  = 1'b1;
               mem_w = 1'b1;
            end
            S_EX_BR: begin
               ALUSrcA  = 1'b1;
               PCSource = PCS_ALUOUT;
               PCWrite  = (opcode == OP_BNE) ? !zero : zero;
            end
            S_EX_J: begin
               PCSource = PCS_JUMP;
               PCWrite  = 1'b1;
            end
            S_EX_JAL: begin
               PCSource = PCS_JUMP;
               PCWrite  = 1'b1;
               RegDst   = RD_RA;
               MemtoReg = M2R_PC;
               RegWrite = 1'b1;
            end
            S_EX_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_WB_I:    RegWrite = 1'b1;
            default: ;
         endcase
      end
   end

   assign CPU_MIO     = mem_r | mem_w;
   assign ALU_Control = rst ? ALU_AND : alu_ctrl;
   assign state_out   = rst ? '0 : STATE_W'(state);

endmodule
